// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline.
// Holds the 32x32 register file, main control decode, immediate extension,
// load-use / branch hazard detection and branch/jump resolution in ID.
// Only the register file is sequential; every other output is combinational
// from the current IF/ID contents and the downstream pipeline-register taps.
module id_stage #(
  parameter int WB_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_Instr,
  input  logic [31:0] IF_PCPlus4,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_RegRt,
  input  logic [4:0]  EX_RegRd,
  input  logic        MEM_MemRead,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_RegRd,
  input  logic [31:0] MEM_ALUResult,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  output logic        ID_MemRead,
  output logic        ID_MemWrite,
  output logic        ID_MemtoReg,
  output logic        ID_RegWrite,
  output logic        ID_ALUSrc,
  output logic [1:0]  ID_ALUOp,
  output logic [31:0] ID_ReadData1,
  output logic [31:0] ID_ReadData2,
  output logic [31:0] ID_InstrExt,
  output logic [4:0]  ID_RegRs,
  output logic [4:0]  ID_RegRt,
  output logic [4:0]  ID_RegRd,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] PCTarget,
  output logic        IF_Flush
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;

  assign w_op  = IF_Instr[31:26];
  assign w_rs  = IF_Instr[25:21];
  assign w_rt  = IF_Instr[20:16];
  assign w_rd  = IF_Instr[15:11];
  assign w_imm = IF_Instr[15:0];

  // Raw decode results, before bubble/reset gating
  logic       w_dec_mem_read;
  logic       w_dec_mem_write;
  logic       w_dec_memto_reg;
  logic       w_dec_reg_write;
  logic       w_dec_alu_src;
  logic [1:0] w_dec_alu_op;
  logic [4:0] w_dest;
  logic       w_uses_rs;
  logic       w_uses_rt;
  logic       w_zero_ext;
  logic       w_is_beq;
  logic       w_is_bne;
  logic       w_is_j;

  // Main control decode: unknown opcodes fall through as a nop with all controls 0
  always_comb begin
    w_dec_mem_read  = 1'b0;
    w_dec_mem_write = 1'b0;
    w_dec_memto_reg = 1'b0;
    w_dec_reg_write = 1'b0;
    w_dec_alu_src   = 1'b0;
    w_dec_alu_op    = 2'b00;
    w_dest          = 5'd0;
    w_uses_rs       = 1'b0;
    w_uses_rt       = 1'b0;
    w_zero_ext      = 1'b0;
    w_is_beq        = 1'b0;
    w_is_bne        = 1'b0;
    w_is_j          = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_dec_reg_write = 1'b1;
        w_dec_alu_op    = 2'b10;
        w_dest          = w_rd;
        w_uses_rs       = 1'b1;
        w_uses_rt       = 1'b1;
      end
      OP_LW: begin
        w_dec_mem_read  = 1'b1;
        w_dec_memto_reg = 1'b1;
        w_dec_reg_write = 1'b1;
        w_dec_alu_src   = 1'b1;
        w_dest          = w_rt;
        w_uses_rs       = 1'b1;
      end
      OP_SW: begin
        w_dec_mem_write = 1'b1;
        w_dec_alu_src   = 1'b1;
        w_uses_rs       = 1'b1;
        w_uses_rt       = 1'b1;
      end
      OP_ADDI: begin
        w_dec_reg_write = 1'b1;
        w_dec_alu_src   = 1'b1;
        w_dest          = w_rt;
        w_uses_rs       = 1'b1;
      end
      OP_ANDI: begin
        w_dec_reg_write = 1'b1;
        w_dec_alu_src   = 1'b1;
        w_dec_alu_op    = 2'b11;
        w_dest          = w_rt;
        w_uses_rs       = 1'b1;
        w_zero_ext      = 1'b1;
      end
      OP_BEQ: begin
        w_dec_alu_op = 2'b01;
        w_uses_rs    = 1'b1;
        w_uses_rt    = 1'b1;
        w_is_beq     = 1'b1;
      end
      OP_BNE: begin
        w_dec_alu_op = 2'b01;
        w_uses_rs    = 1'b1;
        w_uses_rt    = 1'b1;
        w_is_bne     = 1'b1;
      end
      OP_J: begin
        w_is_j = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate extension: andi is the only zero-extending opcode
  logic [31:0] w_sext_imm;
  assign w_sext_imm  = {{16{w_imm[15]}}, w_imm};
  assign ID_InstrExt = w_zero_ext ? {16'd0, w_imm} : w_sext_imm;

  // Register file storage
  logic [31:0] r_regs [0:31];

  // Register file write port; reset clears every entry and beats a WB write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (WB_RegWrite && (WB_WriteReg != 5'd0)) begin
      r_regs[WB_WriteReg] <= WB_WriteData;
    end
  end

  // Read ports: $0 is hardwired, optional same-cycle bypass of the WB write
  logic        w_byp_rs;
  logic        w_byp_rt;
  logic [31:0] w_rf_rs;
  logic [31:0] w_rf_rt;

  assign w_byp_rs = (WB_BYPASS != 0) && WB_RegWrite && (WB_WriteReg == w_rs);
  assign w_byp_rt = (WB_BYPASS != 0) && WB_RegWrite && (WB_WriteReg == w_rt);
  assign w_rf_rs  = (w_rs == 5'd0) ? 32'd0 : (w_byp_rs ? WB_WriteData : r_regs[w_rs]);
  assign w_rf_rt  = (w_rt == 5'd0) ? 32'd0 : (w_byp_rt ? WB_WriteData : r_regs[w_rt]);

  assign ID_ReadData1 = w_rf_rs;
  assign ID_ReadData2 = w_rf_rt;
  assign ID_RegRs     = w_rs;
  assign ID_RegRt     = w_rt;

  // Hazard detection
  logic w_is_branch;
  logic w_load_use;
  logic w_ex_hits;
  logic w_mem_hits;
  logic w_branch_stall;
  logic w_hazard;

  assign w_is_branch = w_is_beq | w_is_bne;

  // A load in EX cannot feed anything this instruction actually reads
  assign w_load_use = EX_MemRead && (EX_RegRt != 5'd0) &&
                      ((w_uses_rs && (EX_RegRt == w_rs)) ||
                       (w_uses_rt && (EX_RegRt == w_rt)));

  // Branches compare in ID, so an ALU result still in EX or a load in MEM is too late
  assign w_ex_hits  = EX_RegWrite && (EX_RegRd != 5'd0) &&
                      ((EX_RegRd == w_rs) || (EX_RegRd == w_rt));
  assign w_mem_hits = MEM_MemRead && (MEM_RegRd != 5'd0) &&
                      ((MEM_RegRd == w_rs) || (MEM_RegRd == w_rt));
  assign w_branch_stall = w_is_branch && (w_ex_hits || w_mem_hits);

  assign w_hazard = w_load_use || w_branch_stall;
  assign Stall    = !rst && w_hazard;

  // Control outputs are bubbled on a stall and held low through reset
  logic w_kill;
  assign w_kill = rst || w_hazard;

  assign ID_MemRead  = w_dec_mem_read  && !w_kill;
  assign ID_MemWrite = w_dec_mem_write && !w_kill;
  assign ID_MemtoReg = w_dec_memto_reg && !w_kill;
  assign ID_RegWrite = w_dec_reg_write && !w_kill;
  assign ID_ALUSrc   = w_dec_alu_src   && !w_kill;
  assign ID_ALUOp    = w_kill ? 2'b00 : w_dec_alu_op;
  assign ID_RegRd    = Stall ? 5'd0 : w_dest;

  // Branch compare operands: an ALU result sitting in EX/MEM overrides the register file
  logic        w_fwd_rs;
  logic        w_fwd_rt;
  logic [31:0] w_cmp_a;
  logic [31:0] w_cmp_b;
  logic        w_equal;
  logic        w_taken;

  assign w_fwd_rs = MEM_RegWrite && !MEM_MemRead && (MEM_RegRd != 5'd0) && (MEM_RegRd == w_rs);
  assign w_fwd_rt = MEM_RegWrite && !MEM_MemRead && (MEM_RegRd != 5'd0) && (MEM_RegRd == w_rt);
  assign w_cmp_a  = w_fwd_rs ? MEM_ALUResult : w_rf_rs;
  assign w_cmp_b  = w_fwd_rt ? MEM_ALUResult : w_rf_rt;
  assign w_equal  = (w_cmp_a == w_cmp_b);
  assign w_taken  = (w_is_beq && w_equal) || (w_is_bne && !w_equal);

  // Target: jump concatenation for j, PC-relative branch formula otherwise
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  assign w_branch_target = IF_PCPlus4 + {w_sext_imm[29:0], 2'b00};
  assign w_jump_target   = {IF_PCPlus4[31:28], IF_Instr[25:0], 2'b00};
  assign PCTarget        = w_is_j ? w_jump_target : w_branch_target;

  // Redirect and flush the single wrong-path slot in IF/ID
  assign PCSrc    = !rst && !w_hazard && (w_taken || w_is_j);
  assign IF_Flush = PCSrc;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage. Two instances share every input: one with
// the WB bypass enabled, one without, so both read-port behaviours are visible
// on the same stimulus. A behavioural model computes expected outputs from the
// instruction semantics and a shadow register array.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PCPlus4;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [4:0]  EX_RegRt;
  logic [4:0]  EX_RegRd;
  logic        MEM_MemRead;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_RegRd;
  logic [31:0] MEM_ALUResult;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;

  logic        b_mr, b_mw, b_m2r, b_rw, b_as, b_stall, b_pcsrc, b_flush;
  logic [1:0]  b_aluop;
  logic [31:0] b_rd1, b_rd2, b_ext, b_target;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic        n_mr, n_mw, n_m2r, n_rw, n_as, n_stall, n_pcsrc, n_flush;
  logic [1:0]  n_aluop;
  logic [31:0] n_rd1, n_rd2, n_ext, n_target;
  logic [4:0]  n_rs, n_rt, n_rd;

  typedef struct packed {
    logic        mr, mw, m2r, rw, as;
    logic [1:0]  aluop;
    logic [31:0] rd1, rd2, ext;
    logic [4:0]  rs, rt, rd;
    logic        stall, pcsrc, flush;
    logic [31:0] target;
  } obs_t;

  logic [31:0] model_rf [0:31];
  int n_checks = 0;
  int n_fail   = 0;

  id_stage #(.WB_BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .IF_Instr(IF_Instr), .IF_PCPlus4(IF_PCPlus4),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_RegRt(EX_RegRt), .EX_RegRd(EX_RegRd),
    .MEM_MemRead(MEM_MemRead), .MEM_RegWrite(MEM_RegWrite), .MEM_RegRd(MEM_RegRd),
    .MEM_ALUResult(MEM_ALUResult), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData),
    .ID_MemRead(b_mr), .ID_MemWrite(b_mw), .ID_MemtoReg(b_m2r), .ID_RegWrite(b_rw),
    .ID_ALUSrc(b_as), .ID_ALUOp(b_aluop), .ID_ReadData1(b_rd1), .ID_ReadData2(b_rd2),
    .ID_InstrExt(b_ext), .ID_RegRs(b_rs), .ID_RegRt(b_rt), .ID_RegRd(b_rd),
    .Stall(b_stall), .PCSrc(b_pcsrc), .PCTarget(b_target), .IF_Flush(b_flush)
  );

  id_stage #(.WB_BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .IF_Instr(IF_Instr), .IF_PCPlus4(IF_PCPlus4),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_RegRt(EX_RegRt), .EX_RegRd(EX_RegRd),
    .MEM_MemRead(MEM_MemRead), .MEM_RegWrite(MEM_RegWrite), .MEM_RegRd(MEM_RegRd),
    .MEM_ALUResult(MEM_ALUResult), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData),
    .ID_MemRead(n_mr), .ID_MemWrite(n_mw), .ID_MemtoReg(n_m2r), .ID_RegWrite(n_rw),
    .ID_ALUSrc(n_as), .ID_ALUOp(n_aluop), .ID_ReadData1(n_rd1), .ID_ReadData2(n_rd2),
    .ID_InstrExt(n_ext), .ID_RegRs(n_rs), .ID_RegRt(n_rt), .ID_RegRd(n_rd),
    .Stall(n_stall), .PCSrc(n_pcsrc), .PCTarget(n_target), .IF_Flush(n_flush)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic obs_t sample(input bit byp);
    obs_t o;
    if (byp) o = '{b_mr, b_mw, b_m2r, b_rw, b_as, b_aluop, b_rd1, b_rd2, b_ext,
                   b_rs, b_rt, b_rd, b_stall, b_pcsrc, b_flush, b_target};
    else     o = '{n_mr, n_mw, n_m2r, n_rw, n_as, n_aluop, n_rd1, n_rd2, n_ext,
                   n_rs, n_rt, n_rd, n_stall, n_pcsrc, n_flush, n_target};
    return o;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'd0;
    if (byp && WB_RegWrite && WB_WriteReg == a) return WB_WriteData;
    return model_rf[a];
  endfunction

  // Reference: instruction semantics from the opcode, hazards as set membership
  function automatic obs_t model(input bit byp);
    obs_t e;
    logic [5:0] op = IF_Instr[31:26];
    logic [4:0] rs = IF_Instr[25:21];
    logic [4:0] rt = IF_Instr[20:16];
    logic [4:0] srcs[$];
    logic [4:0] cmp_regs[$];
    logic [31:0] a, b;
    bit branch, taken, jump, hz;
    int signed off;
    e = '0;
    e.rs = rs;
    e.rt = rt;
    // {MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, ALUOp}
    case (op)
      6'h00: begin {e.mr, e.mw, e.m2r, e.rw, e.as, e.aluop} = 7'b00010_10; e.rd = IF_Instr[15:11]; srcs = '{rs, rt}; end
      6'h23: begin {e.mr, e.mw, e.m2r, e.rw, e.as, e.aluop} = 7'b10111_00; e.rd = rt; srcs = '{rs}; end
      6'h2B: begin {e.mr, e.mw, e.m2r, e.rw, e.as, e.aluop} = 7'b01001_00; srcs = '{rs, rt}; end
      6'h08: begin {e.mr, e.mw, e.m2r, e.rw, e.as, e.aluop} = 7'b00011_00; e.rd = rt; srcs = '{rs}; end
      6'h0C: begin {e.mr, e.mw, e.m2r, e.rw, e.as, e.aluop} = 7'b00011_11; e.rd = rt; srcs = '{rs}; end
      6'h04, 6'h05: begin e.aluop = 2'b01; srcs = '{rs, rt}; end
      default: ;
    endcase
    branch = (op == 6'h04) || (op == 6'h05);
    jump   = (op == 6'h02);
    e.ext  = (op == 6'h0C) ? {16'd0, IF_Instr[15:0]} : 32'($signed(IF_Instr[15:0]));
    e.rd1  = ref_read(rs, byp);
    e.rd2  = ref_read(rt, byp);
    hz = 0;
    if (EX_MemRead && EX_RegRt != 0)
      foreach (srcs[i]) if (srcs[i] == EX_RegRt) hz = 1;
    if (branch) begin
      cmp_regs = '{rs, rt};
      foreach (cmp_regs[i]) begin
        if (EX_RegWrite && EX_RegRd != 0 && EX_RegRd == cmp_regs[i]) hz = 1;
        if (MEM_MemRead && MEM_RegRd != 0 && MEM_RegRd == cmp_regs[i]) hz = 1;
      end
    end
    a = (MEM_RegWrite && !MEM_MemRead && MEM_RegRd != 0 && MEM_RegRd == rs) ? MEM_ALUResult : e.rd1;
    b = (MEM_RegWrite && !MEM_MemRead && MEM_RegRd != 0 && MEM_RegRd == rt) ? MEM_ALUResult : e.rd2;
    taken = (op == 6'h04) ? (a == b) : (op == 6'h05) ? (a != b) : 1'b0;
    off = $signed(IF_Instr[15:0]);
    if (jump) e.target = {IF_PCPlus4[31:28], 28'(IF_Instr[25:0] * 4)};
    else      e.target = IF_PCPlus4 + 32'(off * 4);
    if (rst) begin
      {e.mr, e.mw, e.m2r, e.rw, e.as, e.aluop} = '0;
    end else if (hz) begin
      {e.mr, e.mw, e.m2r, e.rw, e.as, e.aluop} = '0;
      e.rd    = 5'd0;
      e.stall = 1'b1;
    end else if (taken || jump) begin
      e.pcsrc = 1'b1;
      e.flush = 1'b1;
    end
    return e;
  endfunction

  task automatic clear_inputs();
    IF_Instr = 32'd0; IF_PCPlus4 = 32'd0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_RegRt = 0; EX_RegRd = 0;
    MEM_MemRead = 0; MEM_RegWrite = 0; MEM_RegRd = 0; MEM_ALUResult = 32'd0;
    WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 32'd0;
  endtask

  // Finish the current cycle: commit any WB write to the shadow file at the edge
  task automatic step();
    @(posedge clk);
    if (rst) begin
      foreach (model_rf[i]) model_rf[i] = 32'd0;
    end else if (WB_RegWrite && WB_WriteReg != 0) begin
      model_rf[WB_WriteReg] = WB_WriteData;
    end
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    WB_RegWrite = 1; WB_WriteReg = r; WB_WriteData = d;
    step();
    WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 32'd0;
  endtask

  task automatic test_reset();
    obs_t act;
    clear_inputs();
    rst = 1;
    IF_Instr = 32'h8C28FFFC;
    EX_MemRead = 1; EX_RegRt = 5'd1;
    #1;
    @(negedge clk);
    act = sample(1);
    n_checks++;
    if ({act.mr, act.mw, act.m2r, act.rw, act.as, act.aluop, act.stall, act.pcsrc, act.flush} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {act.mr, act.mw, act.m2r, act.rw, act.as, act.aluop, act.stall, act.pcsrc, act.flush});
    end
    step();
    rst = 0;
    clear_inputs();
    IF_Instr = 32'h00A51820;  // add $3,$5,$5
    @(negedge clk);
    act = sample(1);
    n_checks++;
    if (act !== model(1) || act.rd1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rf_clear: got %h required %h", act, model(1));
    end
    step();
  endtask

  task automatic test_regfile();
    obs_t act;
    wb_write(5'd5, 32'h1234);
    IF_Instr = 32'h00A51820;  // add $3,$5,$5
    @(negedge clk);
    act = sample(1);
    n_checks++;
    if (act.rd1 !== 32'h1234 || act.rd2 !== 32'h1234 || act.rd !== 5'd3 || act.aluop !== 2'b10 || act.rw !== 1'b1) begin
      n_fail++;
      $display("FAIL add_read: got rd1=%h rd2=%h rd=%0d aluop=%b rw=%b required 1234 1234 3 10 1", act.rd1, act.rd2, act.rd, act.aluop, act.rw);
    end
    n_checks++;
    if (act !== model(1)) begin
      n_fail++;
      $display("FAIL add_model: got %h required %h", act, model(1));
    end
    step();
    wb_write(5'd0, 32'hFFFF_FFFF);
    IF_Instr = 32'h00000820;  // add $1,$0,$0
    @(negedge clk);
    n_checks++;
    if (b_rd1 !== 32'd0 || n_rd2 !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_reg: got %h/%h required 0", b_rd1, n_rd2);
    end
    step();
  endtask

  task automatic test_bypass();
    IF_Instr = 32'h00E00820;  // add $1,$7,$0
    WB_RegWrite = 1; WB_WriteReg = 5'd7; WB_WriteData = 32'hAAAA;
    @(negedge clk);
    n_checks++;
    if (b_rd1 !== 32'hAAAA) begin
      n_fail++;
      $display("FAIL bypass_on: got %h required 0000aaaa", b_rd1);
    end
    n_checks++;
    if (n_rd1 !== 32'd0) begin
      n_fail++;
      $display("FAIL bypass_off: got %h required 00000000", n_rd1);
    end
    step();
    WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 32'd0;
    @(negedge clk);
    n_checks++;
    if (n_rd1 !== 32'hAAAA) begin
      n_fail++;
      $display("FAIL write_visible: got %h required 0000aaaa", n_rd1);
    end
    step();
  endtask

  task automatic test_load_use();
    obs_t act;
    EX_MemRead = 1; EX_RegRt = 5'd4;
    IF_Instr = 32'hAC440000;  // sw $4,0($2)
    @(negedge clk);
    act = sample(1);
    n_checks++;
    if (act.stall !== 1'b1 || {act.mr, act.mw, act.m2r, act.rw, act.as, act.aluop} !== 7'd0 || act.rd !== 5'd0) begin
      n_fail++;
      $display("FAIL load_use_sw: got stall=%b ctrl=%b rd=%0d required 1 0 0", act.stall, {act.mr, act.mw, act.m2r, act.rw, act.as, act.aluop}, act.rd);
    end
    IF_Instr = 32'h20490001;  // addi $9,$2,1
    #1;
    act = sample(1);
    n_checks++;
    if (act.stall !== 1'b0 || act.rw !== 1'b1 || act.rd !== 5'd9 || act !== model(1)) begin
      n_fail++;
      $display("FAIL load_use_addi: got %h required %h", act, model(1));
    end
    step();
    clear_inputs();
  endtask

  task automatic test_branch();
    obs_t act;
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd5);
    IF_Instr = 32'h1022FFFF;  // beq $1,$2,-1
    IF_PCPlus4 = 32'h100;
    @(negedge clk);
    n_checks++;
    if (b_pcsrc !== 1'b1 || b_flush !== 1'b1 || b_target !== 32'hFC) begin
      n_fail++;
      $display("FAIL beq_taken: got pcsrc=%b flush=%b target=%h required 1 1 000000fc", b_pcsrc, b_flush, b_target);
    end
    MEM_RegWrite = 1; MEM_RegRd = 5'd2; MEM_ALUResult = 32'd6;
    #1;
    n_checks++;
    if (b_pcsrc !== 1'b0 || b_flush !== 1'b0 || b_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_fwd: got pcsrc=%b flush=%b stall=%b required 0 0 0", b_pcsrc, b_flush, b_stall);
    end
    MEM_RegWrite = 0; MEM_RegRd = 0;
    EX_RegWrite = 1; EX_RegRd = 5'd1;
    #1;
    n_checks++;
    if (b_stall !== 1'b1 || b_pcsrc !== 1'b0 || b_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_ex_stall: got stall=%b pcsrc=%b flush=%b required 1 0 0", b_stall, b_pcsrc, b_flush);
    end
    EX_RegWrite = 0; EX_RegRd = 0;
    IF_Instr = 32'h08000040;  // j 0x40
    IF_PCPlus4 = 32'h30000004;
    #1;
    n_checks++;
    if (b_target !== 32'h30000100 || b_flush !== 1'b1 || b_pcsrc !== 1'b1) begin
      n_fail++;
      $display("FAIL jump: got target=%h flush=%b pcsrc=%b required 30000100 1 1", b_target, b_flush, b_pcsrc);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_extend();
    IF_Instr = 32'h30288000;  // andi $8,$1,0x8000
    @(negedge clk);
    n_checks++;
    if (b_ext !== 32'h00008000 || b_aluop !== 2'b11) begin
      n_fail++;
      $display("FAIL andi_ext: got ext=%h aluop=%b required 00008000 11", b_ext, b_aluop);
    end
    IF_Instr = 32'h8C28FFFC;  // lw $8,-4($1)
    #1;
    n_checks++;
    if (b_ext !== 32'hFFFFFFFC || b_rd !== 5'd8 || b_m2r !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_ext: got ext=%h rd=%0d m2r=%b required fffffffc 8 1", b_ext, b_rd, b_m2r);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    IF_Instr = 32'h8C28FFFC;  // lw $8,-4($1), $1 holds 5
    EX_MemRead = 1; EX_RegRt = 5'd1;
    @(negedge clk);
    n_checks++;
    if (b_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stall_pre: got %b required 1", b_stall);
    end
    rst = 1;
    #1;
    n_checks++;
    if (b_stall !== 1'b0 || n_stall !== 1'b0 || b_mr !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_stall_rst: got stall=%b/%b mr=%b required 0 0 0", b_stall, n_stall, b_mr);
    end
    step();
    rst = 0;
    clear_inputs();
    IF_Instr = 32'h8C28FFFC;
    @(negedge clk);
    n_checks++;
    if (b_rd1 !== 32'd0 || n_rd1 !== 32'd0 || b_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_stall_clear: got rd1=%h/%h stall=%b required 0 0 0", b_rd1, n_rd1, b_stall);
    end
    step();
  endtask

  task automatic test_random(input int n);
    logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h04, 6'h05, 6'h02, 6'h3F};
    obs_t act;
    for (int k = 0; k < n; k++) begin
      IF_Instr = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 11'($urandom)};
      IF_PCPlus4    = $urandom;
      EX_MemRead    = 1'($urandom_range(0, 1));
      EX_RegWrite   = 1'($urandom_range(0, 1));
      EX_RegRt      = 5'($urandom_range(0, 7));
      EX_RegRd      = 5'($urandom_range(0, 7));
      MEM_MemRead   = ($urandom_range(0, 3) == 0);
      MEM_RegWrite  = 1'($urandom_range(0, 1));
      MEM_RegRd     = 5'($urandom_range(0, 7));
      MEM_ALUResult = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      WB_RegWrite   = 1'($urandom_range(0, 1));
      WB_WriteReg   = 5'($urandom_range(0, 7));
      WB_WriteData  = 32'($urandom_range(0, 3));
      @(negedge clk);
      act = sample(1);
      n_checks++;
      if (act !== model(1)) begin
        n_fail++;
        $display("FAIL rand_byp[%0d] instr=%h: got %h required %h", k, IF_Instr, act, model(1));
      end
      act = sample(0);
      n_checks++;
      if (act !== model(0)) begin
        n_fail++;
        $display("FAIL rand_nobyp[%0d] instr=%h: got %h required %h", k, IF_Instr, act, model(0));
      end
      step();
    end
    clear_inputs();
  endtask

  // Test sequence
  initial begin
    foreach (model_rf[i]) model_rf[i] = 32'd0;
    rst = 0;
    clear_inputs();
    #2;
    test_reset();
    test_regfile();
    test_bypass();
    test_load_use();
    test_branch();
    test_extend();
    test_reset_mid_stall();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
